// File: rtl/chip_frame.sv
// chip_frame: collects gated chip bursts into a payload FIFO plus a 4-entry
// descriptor FIFO, and replays each complete chip as a framed word stream
// {HEAD, chip_id, len, payload..., checksum} over a valid/ready interface.
module chip_frame #(
   parameter int unsigned DEPTH_LOG2 = 12,
   parameter logic [15:0] HEAD       = 16'hA55A
) (
   input  logic        clk_sys,
   input  logic        rst_n,
   input  logic [15:0] d1_data,
   input  logic        d1_vld,
   input  logic [19:0] cfg_len,
   output logic [15:0] fr_data,
   output logic        fr_vld,
   input  logic        fr_rdy,
   output logic        fr_sof,
   output logic        fr_eof,
   output logic [15:0] stat_chip_cnt,
   output logic [15:0] stat_drop_cnt,
   output logic        busy
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_C = {1'b1, {DEPTH_LOG2{1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_HEAD, S_ID, S_LEN, S_PAY, S_SUM} state_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // payload FIFO
   logic [15:0]           mem_q [0:DEPTH-1];
   logic [DEPTH_LOG2-1:0] pwr_q, prd_q;
   logic [DEPTH_LOG2:0]   pcnt_q, free_w;
   // descriptor FIFO
   logic [15:0] did_q [0:3];
   logic [15:0] dlen_q [0:3];
   logic [15:0] dsum_q [0:3];
   logic [1:0]  dwr_q, drd_q;
   logic [2:0]  dcnt_q;
   // write side
   logic [19:0] wcnt_q, wcnt_d, len_q, len_d;
   logic        acc_q, acc_d;
   logic [15:0] sum_q, sum_d, chip_id_q, chip_cnt_q, drop_cnt_q;
   logic        pwr_en, chip_end, dpush, ddrop;
   // read side
   state_t      state_q;
   logic [15:0] fr_data_q, pay_q;
   logic        fr_vld_q, fr_sof_q, fr_eof_q;
   logic        xfer, pay_last, prd_en, dpop;

   assign xfer     = fr_vld_q & fr_rdy;
   assign pay_last = (pay_q == dlen_q[drd_q]);
   // a payload word leaves the FIFO when it is loaded into the output register
   assign prd_en   = xfer & ((state_q == S_LEN) | ((state_q == S_PAY) & ~pay_last));
   assign dpop     = xfer & (state_q == S_SUM);
   assign free_w   = DEPTH_C - pcnt_q + {{DEPTH_LOG2{1'b0}}, prd_en};

   // Chip start/accept decision, write counter, checksum and chip end
   always_comb begin
      wcnt_d   = wcnt_q;
      len_d    = len_q;
      acc_d    = acc_q;
      sum_d    = sum_q;
      pwr_en   = 1'b0;
      chip_end = 1'b0;
      if (d1_vld) begin
         if (wcnt_q == 20'd0) begin
            if (cfg_len != 20'd0) begin
               len_d  = cfg_len;
               acc_d  = (32'(free_w) >= 32'(cfg_len)) && (dcnt_q != 3'd4);
               sum_d  = d1_data;
               wcnt_d = 20'd1;
               pwr_en = acc_d;
            end
         end else begin
            sum_d  = sum_q + d1_data;
            wcnt_d = wcnt_q + 20'd1;
            pwr_en = acc_q;
         end
         if ((wcnt_d != 20'd0) && (wcnt_d == len_d)) begin
            chip_end = 1'b1;
            wcnt_d   = 20'd0;
         end
      end
   end

   assign dpush = chip_end & acc_d;
   assign ddrop = chip_end & ~acc_d;

   // Control state: FIFO pointers/occupancy, chip tracking and statistics
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         pwr_q      <= '0;
         prd_q      <= '0;
         pcnt_q     <= '0;
         dwr_q      <= '0;
         drd_q      <= '0;
         dcnt_q     <= '0;
         wcnt_q     <= '0;
         len_q      <= '0;
         acc_q      <= 1'b0;
         chip_id_q  <= '0;
         chip_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         if (pwr_en) pwr_q <= pwr_q + 1'b1;
         if (prd_en) prd_q <= prd_q + 1'b1;
         pcnt_q <= pcnt_q + {{DEPTH_LOG2{1'b0}}, pwr_en} - {{DEPTH_LOG2{1'b0}}, prd_en};
         if (dpush) dwr_q <= dwr_q + 2'd1;
         if (dpop)  drd_q <= drd_q + 2'd1;
         dcnt_q <= dcnt_q + {2'b00, dpush} - {2'b00, dpop};
         wcnt_q <= wcnt_d;
         len_q  <= len_d;
         acc_q  <= acc_d;
         if (chip_end) chip_id_q <= chip_id_q + 16'd1;
         if (dpush) chip_cnt_q <= sat_inc(chip_cnt_q);
         if (ddrop) drop_cnt_q <= sat_inc(drop_cnt_q);
      end
   end

   // Data storage: payload memory, descriptor entries and running checksum
   always_ff @(posedge clk_sys) begin
      if (pwr_en) mem_q[pwr_q] <= d1_data;
      if (dpush) begin
         did_q[dwr_q]  <= chip_id_q;
         dlen_q[dwr_q] <= len_d[15:0];
         dsum_q[dwr_q] <= sum_d;
      end
      sum_q <= sum_d;
   end

   // Read FSM: state names the word currently held in the output register
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         fr_data_q <= '0;
         fr_vld_q  <= 1'b0;
         fr_sof_q  <= 1'b0;
         fr_eof_q  <= 1'b0;
         pay_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (dcnt_q != 3'd0) begin
               state_q   <= S_HEAD;
               fr_vld_q  <= 1'b1;
               fr_data_q <= HEAD;
               fr_sof_q  <= 1'b1;
            end
            S_HEAD: if (xfer) begin
               state_q   <= S_ID;
               fr_data_q <= did_q[drd_q];
               fr_sof_q  <= 1'b0;
            end
            S_ID: if (xfer) begin
               state_q   <= S_LEN;
               fr_data_q <= dlen_q[drd_q];
            end
            S_LEN: if (xfer) begin
               state_q   <= S_PAY;
               fr_data_q <= mem_q[prd_q];
               pay_q     <= 16'd1;
            end
            S_PAY: if (xfer) begin
               if (pay_last) begin
                  state_q   <= S_SUM;
                  fr_data_q <= dsum_q[drd_q];
                  fr_eof_q  <= 1'b1;
               end else begin
                  fr_data_q <= mem_q[prd_q];
                  pay_q     <= pay_q + 16'd1;
               end
            end
            S_SUM: if (xfer) begin
               fr_eof_q <= 1'b0;
               // dcnt_q still counts the descriptor being popped now
               if (dcnt_q > 3'd1) begin
                  state_q   <= S_HEAD;
                  fr_data_q <= HEAD;
                  fr_sof_q  <= 1'b1;
               end else begin
                  state_q  <= S_IDLE;
                  fr_vld_q <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign fr_data       = fr_data_q;
   assign fr_vld        = fr_vld_q;
   assign fr_sof        = fr_sof_q;
   assign fr_eof        = fr_eof_q;
   assign stat_chip_cnt = chip_cnt_q;
   assign stat_drop_cnt = drop_cnt_q;
   assign busy          = (wcnt_q != 20'd0) | (dcnt_q != 3'd0) | (state_q != S_IDLE);

endmodule

// File: tb/tb_chip_frame.sv
// tb_chip_frame: randomized and directed stimulus for chip_frame, checked
// against a word-level frame model kept in this bench.
module tb_chip_frame;

   localparam int DL2   = 5;
   localparam int DEPTH = 32;

   logic        clk_sys = 1'b0;
   logic        rst_n   = 1'b0;
   logic [15:0] d1_data = '0;
   logic        d1_vld  = 1'b0;
   logic [19:0] cfg_len = '0;
   logic        fr_rdy  = 1'b0;
   logic [15:0] fr_data, stat_chip_cnt, stat_drop_cnt;
   logic        fr_vld, fr_sof, fr_eof, busy;

   always #5 clk_sys = ~clk_sys;

   chip_frame #(.DEPTH_LOG2(DL2), .HEAD(16'hA55A)) dut (
      .clk_sys(clk_sys), .rst_n(rst_n), .d1_data(d1_data), .d1_vld(d1_vld),
      .cfg_len(cfg_len), .fr_data(fr_data), .fr_vld(fr_vld), .fr_rdy(fr_rdy),
      .fr_sof(fr_sof), .fr_eof(fr_eof), .stat_chip_cnt(stat_chip_cnt),
      .stat_drop_cnt(stat_drop_cnt), .busy(busy)
   );

   typedef struct packed {
      logic [15:0] w;
      logic        sof;
      logic        eof;
      logic        pay;
   } fw_t;

   fw_t         exp_q[$];
   logic [15:0] got_q[$];
   logic [15:0] pay_buf[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          m_wcnt, m_len, m_stored;
   bit          m_acc, in_frame, prev_stall;
   logic [15:0] m_sum, m_id, m_chip, m_drop;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      exp_q.delete();
      pay_buf.delete();
      m_wcnt = 0; m_len = 0; m_stored = 0; m_acc = 1'b0;
      m_sum = '0; m_id = '0; m_chip = '0; m_drop = '0;
      in_frame = 1'b0; prev_stall = 1'b0;
   endfunction

   function automatic void push_w(input logic [15:0] w, input logic s, input logic e, input logic p);
      fw_t f;
      f.w = w; f.sof = s; f.eof = e; f.pay = p;
      exp_q.push_back(f);
   endfunction

   // One clock of the reference model: check outputs, then account for the
   // handshake and the sample entering on the coming edge.
   task automatic model_step();
      fw_t h;
      int  dcount, free_w;
      bit  xfer, rd_now, active;
      chk("busy", busy, (m_wcnt != 0 || exp_q.size() != 0));
      chk("chip_cnt", stat_chip_cnt, m_chip);
      chk("drop_cnt", stat_drop_cnt, m_drop);
      if (prev_stall || in_frame) chk("vld_hold", fr_vld, 1);
      if (fr_vld) begin
         if (exp_q.size() == 0) chk("spurious_vld", fr_vld, 0);
         else begin
            chk("fr_data", fr_data, exp_q[0].w);
            chk("fr_sof", fr_sof, exp_q[0].sof);
            chk("fr_eof", fr_eof, exp_q[0].eof);
         end
      end
      dcount = 0;
      foreach (exp_q[i]) if (exp_q[i].eof) dcount++;
      xfer = fr_vld && fr_rdy && exp_q.size() != 0;
      if (xfer) begin
         got_q.push_back(fr_data);
         h = exp_q.pop_front();
         in_frame = !h.eof;
      end
      // the next payload word is fetched as soon as its predecessor leaves
      rd_now = xfer && exp_q.size() != 0 && exp_q[0].pay;
      free_w = DEPTH - m_stored + int'(rd_now);
      if (rd_now) m_stored--;
      prev_stall = fr_vld && !fr_rdy;
      if (d1_vld) begin
         active = (m_wcnt != 0);
         if (m_wcnt == 0 && cfg_len != 0) begin
            m_len  = int'(cfg_len);
            m_acc  = (m_len <= free_w) && (dcount < 4);
            m_sum  = '0;
            pay_buf.delete();
            active = 1'b1;
         end
         if (active) begin
            m_wcnt++;
            m_sum = m_sum + d1_data;
            if (m_acc) begin
               pay_buf.push_back(d1_data);
               m_stored++;
            end
            if (m_wcnt == m_len) begin
               if (m_acc) begin
                  push_w(16'hA55A, 1, 0, 0);
                  push_w(m_id, 0, 0, 0);
                  push_w(16'(m_len), 0, 0, 0);
                  foreach (pay_buf[i]) push_w(pay_buf[i], 0, 0, 1);
                  push_w(m_sum, 0, 1, 0);
                  if (m_chip != 16'hFFFF) m_chip++;
               end else if (m_drop != 16'hFFFF) m_drop++;
               m_id++;
               m_wcnt = 0;
            end
         end
      end
   endtask

   task automatic cycle(input logic v, input logic [15:0] d, input logic [19:0] l, input logic r);
      @(negedge clk_sys);
      d1_vld = v; d1_data = d; cfg_len = l; fr_rdy = r;
      model_step();
   endtask

   task automatic do_reset();
      @(negedge clk_sys);
      rst_n = 1'b0; d1_vld = 1'b0; fr_rdy = 1'b0;
      model_reset();
      @(negedge clk_sys);
      @(negedge clk_sys);
      rst_n = 1'b1;
      got_q.delete();
   endtask

   task automatic drain(input bit rnd);
      int n = 0;
      while ((exp_q.size() != 0 || fr_vld) && n < 3000) begin
         cycle(1'b0, 16'h0, cfg_len, rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
         n++;
      end
      chk("drain_done", exp_q.size(), 0);
   endtask

   task automatic check_frames(input string tag, input int nfr, input int flen);
      chk({tag, "_words"}, got_q.size(), nfr * (flen + 4));
      for (int k = 0; k < nfr; k++)
         if (k * (flen + 4) + 1 < got_q.size())
            chk({tag, "_id"}, got_q[k * (flen + 4) + 1], k);
   endtask

   task automatic check_single(input string tag);
      logic [15:0] ref1 [14];
      ref1 = '{16'hA55A, 16'h0000, 16'h000A, 16'h0001, 16'h0002, 16'h0003, 16'h0004,
               16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h0009, 16'h000A, 16'h0037};
      chk({tag, "_len"}, got_q.size(), 14);
      for (int i = 0; i < 14; i++)
         if (i < got_q.size()) chk({tag, "_word"}, got_q[i], ref1[i]);
   endtask

   initial begin
      int lat, n;
      model_reset();
      repeat (2) @(negedge clk_sys);
      rst_n = 1'b1;
      chk("rst_fr_data", fr_data, 0);
      chk("rst_fr_vld", fr_vld, 0);
      chk("rst_fr_sof", fr_sof, 0);
      chk("rst_fr_eof", fr_eof, 0);
      chk("rst_stats", {stat_chip_cnt, stat_drop_cnt}, 0);
      chk("rst_busy", busy, 0);

      // single chip, ready held high
      got_q.delete();
      for (int i = 1; i <= 10; i++) cycle(1'b1, 16'(i), 20'd10, 1'b1);
      lat = 0;
      while (!fr_vld && lat < 8) begin cycle(1'b0, 16'h0, 20'd10, 1'b1); lat++; end
      chk("hdr_latency_ok", (lat >= 2 && lat <= 5), 1);
      drain(1'b0);
      check_single("single");
      chk("single_chip_cnt", stat_chip_cnt, 1);

      // same chip under random backpressure
      do_reset();
      for (int i = 1; i <= 10; i++) cycle(1'b1, 16'(i), 20'd10, $urandom_range(0, 1) != 0);
      drain(1'b1);
      check_single("bp");

      // payload overflow: fourth chip does not fit
      do_reset();
      for (int c = 0; c < 4; c++)
         for (int i = 1; i <= 10; i++) cycle(1'b1, 16'(c * 16 + i), 20'd10, 1'b0);
      cycle(1'b0, 16'h0, 20'd10, 1'b0);
      chk("ovf_drop", stat_drop_cnt, 1);
      chk("ovf_chip", stat_chip_cnt, 3);
      drain(1'b0);
      check_frames("ovf", 3, 10);

      // descriptor FIFO full: fifth chip dropped
      do_reset();
      for (int c = 0; c < 5; c++)
         for (int i = 1; i <= 4; i++) cycle(1'b1, 16'($urandom), 20'd4, 1'b0);
      cycle(1'b0, 16'h0, 20'd4, 1'b0);
      chk("dfull_drop", stat_drop_cnt, 1);
      chk("dfull_chip", stat_chip_cnt, 4);
      drain(1'b0);
      check_frames("dfull", 4, 4);

      // cfg_len change mid-chip applies only from the next chip
      do_reset();
      for (int i = 1; i <= 10; i++) cycle(1'b1, 16'(i), (i <= 3) ? 20'd10 : 20'd6, 1'b1);
      for (int i = 1; i <= 6; i++) cycle(1'b1, 16'(i + 100), 20'd6, 1'b1);
      drain(1'b0);
      chk("cfgchg_words", got_q.size(), 24);
      if (got_q.size() >= 17) begin
         chk("cfgchg_len0", got_q[2], 16'h000A);
         chk("cfgchg_len1", got_q[16], 16'h0006);
      end

      // zero length: samples ignored
      do_reset();
      for (int i = 0; i < 8; i++) cycle(1'b1, 16'(i), 20'd0, 1'b1);
      cycle(1'b0, 16'h0, 20'd0, 1'b1);
      cycle(1'b0, 16'h0, 20'd0, 1'b1);
      chk("zero_vld", fr_vld, 0);
      chk("zero_stats", {stat_chip_cnt, stat_drop_cnt}, 0);
      chk("zero_busy", busy, 0);

      // reset in the middle of payload
      do_reset();
      for (int i = 1; i <= 10; i++) cycle(1'b1, 16'(i), 20'd10, 1'b1);
      n = 0;
      while (got_q.size() < 5 && n < 40) begin cycle(1'b0, 16'h0, 20'd10, 1'b1); n++; end
      chk("midpay_reached", got_q.size(), 5);
      @(negedge clk_sys);
      rst_n = 1'b0; d1_vld = 1'b0; fr_rdy = 1'b0;
      #1;
      chk("midpay_rst_vld", fr_vld, 0);
      chk("midpay_rst_busy", busy, 0);
      chk("midpay_rst_chip", stat_chip_cnt, 0);
      model_reset();
      got_q.delete();
      @(negedge clk_sys);
      @(negedge clk_sys);
      rst_n = 1'b1;
      for (int i = 7; i <= 9; i++) cycle(1'b1, 16'(i), 20'd3, 1'b1);
      drain(1'b0);
      chk("midpay_words", got_q.size(), 7);
      if (got_q.size() >= 7) begin
         chk("midpay_id", got_q[1], 16'h0000);
         chk("midpay_sum", got_q[6], 16'h0018);
      end

      // randomized traffic
      do_reset();
      for (int i = 0; i < 1500; i++)
         cycle($urandom_range(0, 3) != 0, 16'($urandom), 20'($urandom_range(0, 40)),
               $urandom_range(0, 2) != 0);
      n = 0;
      while (m_wcnt != 0 && n < 100) begin cycle(1'b1, 16'($urandom), 20'd5, 1'b1); n++; end
      chk("rand_chip_closed", m_wcnt, 0);
      drain(1'b1);
      cycle(1'b0, 16'h0, 20'd0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
